// File: rtl/lsu_issue_queue.sv
// Age-ordered load/store reservation queue. It wakes operands from the CDB and
// issues the oldest eligible op, blocking loads behind older stores.
module lsu_issue_queue #(
  parameter int DEPTH    = 8,
  parameter int DISPATCH = 2,
  parameter int CDB_N    = 2,
  parameter int ROB_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  output logic [DISPATCH-1:0]             alloc_ready,
  input  logic [DISPATCH-1:0]             disp_valid,
  input  logic [DISPATCH-1:0][ROB_W-1:0]  disp_reorder,
  input  logic [DISPATCH-1:0]             disp_is_store,
  input  logic [DISPATCH-1:0][1:0]        disp_size,
  input  logic [DISPATCH-1:0][DATA_W-1:0] disp_imm,
  input  logic [DISPATCH-1:0]             disp_base_rdy,
  input  logic [DISPATCH-1:0]             disp_sd_rdy,
  input  logic [DISPATCH-1:0][DATA_W-1:0] disp_base,
  input  logic [DISPATCH-1:0][DATA_W-1:0] disp_sd,
  input  logic [CDB_N-1:0]                cdb_valid,
  input  logic [CDB_N-1:0][ROB_W-1:0]     cdb_reorder,
  input  logic [CDB_N-1:0][DATA_W-1:0]    cdb_value,
  output logic                            iss_valid,
  input  logic                            iss_ready,
  output logic [ROB_W-1:0]                iss_reorder,
  output logic                            iss_is_store,
  output logic [1:0]                      iss_size,
  output logic [DATA_W-1:0]               iss_vaddr,
  output logic [DATA_W-1:0]               iss_wdata,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            empty
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]             valid_q;
  logic [DEPTH-1:0][ROB_W-1:0]  reorder_q;
  logic [DEPTH-1:0]             store_q;
  logic [DEPTH-1:0][1:0]        size_q;
  logic [DEPTH-1:0][DATA_W-1:0] imm_q;
  logic [DEPTH-1:0]             base_rdy_q;
  logic [DEPTH-1:0][DATA_W-1:0] base_q;
  logic [DEPTH-1:0]             sd_rdy_q;
  logic [DEPTH-1:0][DATA_W-1:0] sd_q;
  // older_q[i][j] set means entry j is older than entry i (meaningful only while both are valid)
  logic [DEPTH-1:0][DEPTH-1:0]  older_q;
  logic                         lock_q;
  logic [IDX_W-1:0]             lock_idx_q;

  logic [DEPTH-1:0][DATA_W:0]    ent_base_lk, ent_sd_lk;
  logic [DISPATCH-1:0][DATA_W:0] disp_base_lk, disp_sd_lk;
  logic [DISPATCH-1:0]              new_base_rdy, new_sd_rdy;
  logic [DISPATCH-1:0][DATA_W-1:0]  new_base, new_sd;
  logic [DISPATCH-1:0]              accept;
  logic [DISPATCH-1:0][IDX_W-1:0]   alloc_idx;
  logic [DISPATCH-1:0][DEPTH-1:0]   prior;
  logic [DEPTH-1:0]                 alloc_mask;
  logic [DISPATCH-1:0]              ar_next;
  int                               n_accept, next_count;
  logic [DEPTH-1:0]                 elig;
  logic                             any_elig;
  logic [IDX_W-1:0]                 sel_idx, iss_idx;
  logic                             fire;

  // Returns {hit, value}; scanning downward lets the lowest-numbered bus win.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [ROB_W-1:0]             tag,
    input logic [CDB_N-1:0]             bus_valid,
    input logic [CDB_N-1:0][ROB_W-1:0]  bus_reorder,
    input logic [CDB_N-1:0][DATA_W-1:0] bus_value
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int j = CDB_N - 1; j >= 0; j--)
      if (bus_valid[j] && bus_reorder[j] == tag) r = {1'b1, bus_value[j]};
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_base_lk[i] = cdb_lookup(base_q[i][ROB_W-1:0], cdb_valid, cdb_reorder, cdb_value);
      ent_sd_lk[i]   = cdb_lookup(sd_q[i][ROB_W-1:0], cdb_valid, cdb_reorder, cdb_value);
    end
    for (int k = 0; k < DISPATCH; k++) begin
      disp_base_lk[k] = cdb_lookup(disp_base[k][ROB_W-1:0], cdb_valid, cdb_reorder, cdb_value);
      disp_sd_lk[k]   = cdb_lookup(disp_sd[k][ROB_W-1:0], cdb_valid, cdb_reorder, cdb_value);
    end
  end

  // Loads carry no store data, so their sd operand is born ready and zero.
  always_comb begin
    for (int k = 0; k < DISPATCH; k++) begin
      new_base_rdy[k] = disp_base_rdy[k] | disp_base_lk[k][DATA_W];
      new_base[k]     = (!disp_base_rdy[k] && disp_base_lk[k][DATA_W]) ?
                        disp_base_lk[k][DATA_W-1:0] : disp_base[k];
      if (!disp_is_store[k]) begin
        new_sd_rdy[k] = 1'b1;
        new_sd[k]     = '0;
      end else begin
        new_sd_rdy[k] = disp_sd_rdy[k] | disp_sd_lk[k][DATA_W];
        new_sd[k]     = (!disp_sd_rdy[k] && disp_sd_lk[k][DATA_W]) ?
                        disp_sd_lk[k][DATA_W-1:0] : disp_sd[k];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (store_q[i])
        elig[i] = valid_q[i] & base_rdy_q[i] & sd_rdy_q[i] & ~|(older_q[i] & valid_q);
      else
        elig[i] = valid_q[i] & base_rdy_q[i] & ~|(older_q[i] & valid_q & store_q);
    end
  end

  always_comb begin
    sel_idx  = '0;
    any_elig = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (elig[i] && ((older_q[i] & elig) == '0)) begin
        sel_idx  = IDX_W'(i);
        any_elig = 1'b1;
      end
  end

  assign iss_idx      = lock_q ? lock_idx_q : sel_idx;
  assign iss_valid    = lock_q | any_elig;
  assign fire         = iss_valid & iss_ready;
  assign iss_reorder  = reorder_q[iss_idx];
  assign iss_is_store = store_q[iss_idx];
  assign iss_size     = size_q[iss_idx];
  assign iss_vaddr    = base_q[iss_idx] + imm_q[iss_idx];
  assign iss_wdata    = store_q[iss_idx] ? sd_q[iss_idx] : '0;
  assign empty        = (count == '0);

  // alloc_ready guarantees enough free entries exist for every accepted slot.
  always_comb begin
    accept     = disp_valid & alloc_ready;
    alloc_mask = '0;
    n_accept   = 0;
    for (int k = 0; k < DISPATCH; k++) begin
      prior[k]     = alloc_mask;
      alloc_idx[k] = '0;
      if (accept[k]) begin
        n_accept = n_accept + 1;
        for (int i = DEPTH - 1; i >= 0; i--)
          if (!valid_q[i] && !prior[k][i]) alloc_idx[k] = IDX_W'(i);
        alloc_mask[alloc_idx[k]] = 1'b1;
      end
    end
    next_count = int'(count) + n_accept - (fire ? 1 : 0);
    for (int k = 0; k < DISPATCH; k++)
      ar_next[k] = (DEPTH - next_count) > k;
  end

  // Reallocated entries clear their column first so stale age bits never survive reuse.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q     <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      count       <= '0;
      alloc_ready <= '1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!base_rdy_q[i] && ent_base_lk[i][DATA_W]) begin
          base_rdy_q[i] <= 1'b1;
          base_q[i]     <= ent_base_lk[i][DATA_W-1:0];
        end
        if (!sd_rdy_q[i] && ent_sd_lk[i][DATA_W]) begin
          sd_rdy_q[i] <= 1'b1;
          sd_q[i]     <= ent_sd_lk[i][DATA_W-1:0];
        end
        for (int j = 0; j < DEPTH; j++)
          if (alloc_mask[i]) older_q[j][i] <= 1'b0;
      end
      if (fire) valid_q[iss_idx] <= 1'b0;
      for (int k = 0; k < DISPATCH; k++)
        if (accept[k]) begin
          valid_q[alloc_idx[k]]    <= 1'b1;
          reorder_q[alloc_idx[k]]  <= disp_reorder[k];
          store_q[alloc_idx[k]]    <= disp_is_store[k];
          size_q[alloc_idx[k]]     <= disp_size[k];
          imm_q[alloc_idx[k]]      <= disp_imm[k];
          base_rdy_q[alloc_idx[k]] <= new_base_rdy[k];
          base_q[alloc_idx[k]]     <= new_base[k];
          sd_rdy_q[alloc_idx[k]]   <= new_sd_rdy[k];
          sd_q[alloc_idx[k]]       <= new_sd[k];
          older_q[alloc_idx[k]]    <= valid_q | prior[k];
        end
      if (fire)
        lock_q <= 1'b0;
      else if (iss_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= iss_idx;
      end
      count       <= CNT_W'(next_count);
      alloc_ready <= ar_next;
    end
  end
endmodule

// File: tb/tb_lsu_issue_queue.sv
// Bench for lsu_issue_queue: directed scenarios then random traffic, all
// compared against an age-ordered list model of the queue.
module tb_lsu_issue_queue;
  localparam int DEPTH = 8, DISPATCH = 2, CDB_N = 2, ROB_W = 5, DATA_W = 32;

  logic clk = 1'b0;
  logic rst, flush;
  logic [DISPATCH-1:0]             alloc_ready;
  logic [DISPATCH-1:0]             disp_valid;
  logic [DISPATCH-1:0][ROB_W-1:0]  disp_reorder;
  logic [DISPATCH-1:0]             disp_is_store;
  logic [DISPATCH-1:0][1:0]        disp_size;
  logic [DISPATCH-1:0][DATA_W-1:0] disp_imm;
  logic [DISPATCH-1:0]             disp_base_rdy, disp_sd_rdy;
  logic [DISPATCH-1:0][DATA_W-1:0] disp_base, disp_sd;
  logic [CDB_N-1:0]                cdb_valid;
  logic [CDB_N-1:0][ROB_W-1:0]     cdb_reorder;
  logic [CDB_N-1:0][DATA_W-1:0]    cdb_value;
  logic                            iss_valid, iss_ready;
  logic [ROB_W-1:0]                iss_reorder;
  logic                            iss_is_store;
  logic [1:0]                      iss_size;
  logic [DATA_W-1:0]               iss_vaddr, iss_wdata;
  logic [3:0]                      count;
  logic                            empty;

  always #5 clk = ~clk;

  lsu_issue_queue #(.DEPTH(DEPTH), .DISPATCH(DISPATCH), .CDB_N(CDB_N),
                    .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_ready(alloc_ready),
    .disp_valid(disp_valid), .disp_reorder(disp_reorder), .disp_is_store(disp_is_store),
    .disp_size(disp_size), .disp_imm(disp_imm), .disp_base_rdy(disp_base_rdy),
    .disp_sd_rdy(disp_sd_rdy), .disp_base(disp_base), .disp_sd(disp_sd),
    .cdb_valid(cdb_valid), .cdb_reorder(cdb_reorder), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_reorder(iss_reorder),
    .iss_is_store(iss_is_store), .iss_size(iss_size), .iss_vaddr(iss_vaddr),
    .iss_wdata(iss_wdata), .count(count), .empty(empty)
  );

  typedef struct {
    int unsigned      id;
    logic [ROB_W-1:0] rob;
    logic             st;
    logic [1:0]       size;
    logic [31:0]      imm;
    logic             brdy;
    logic [31:0]      base;
    logic             srdy;
    logic [31:0]      sd;
  } ent_t;

  // Model queue is kept in age order: index 0 is the oldest op.
  ent_t        mq[$];
  bit          m_lock;
  int unsigned m_lock_id;
  int unsigned m_next_id = 0;
  logic [1:0]  m_ar = 2'b11;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  function automatic ent_t m_wake(input ent_t e);
    ent_t r;
    r = e;
    for (int j = 0; j < CDB_N; j++) begin
      if (!r.brdy && cdb_valid[j] && cdb_reorder[j] == r.base[ROB_W-1:0]) begin
        r.brdy = 1'b1;
        r.base = cdb_value[j];
      end
      if (!r.srdy && cdb_valid[j] && cdb_reorder[j] == r.sd[ROB_W-1:0]) begin
        r.srdy = 1'b1;
        r.sd   = cdb_value[j];
      end
    end
    return r;
  endfunction

  task automatic m_pick(output bit found, output int pos);
    bit store_seen;
    store_seen = 1'b0;
    found = 1'b0;
    pos = 0;
    if (m_lock) begin
      foreach (mq[i]) if (mq[i].id == m_lock_id) begin found = 1'b1; pos = i; end
      return;
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (!found) begin
        if (mq[i].st) begin
          if (i == 0 && mq[i].brdy && mq[i].srdy) begin found = 1'b1; pos = i; end
        end else if (mq[i].brdy && !store_seen) begin
          found = 1'b1; pos = i;
        end
      end
      if (mq[i].st) store_seen = 1'b1;
    end
  endtask

  task automatic m_step();
    bit   f;
    int   p;
    ent_t e;
    m_pick(f, p);
    if (rst || flush) begin
      mq.delete();
      m_lock = 1'b0;
      m_ar   = 2'b11;
      return;
    end
    foreach (mq[i]) mq[i] = m_wake(mq[i]);
    if (f && !iss_ready) begin m_lock = 1'b1; m_lock_id = mq[p].id; end
    if (f && iss_ready) begin mq.delete(p); m_lock = 1'b0; end
    for (int k = 0; k < DISPATCH; k++)
      if (disp_valid[k] && m_ar[k]) begin
        e.id   = m_next_id;
        m_next_id++;
        e.rob  = disp_reorder[k];
        e.st   = disp_is_store[k];
        e.size = disp_size[k];
        e.imm  = disp_imm[k];
        e.brdy = disp_base_rdy[k];
        e.base = disp_base[k];
        e.srdy = !e.st || disp_sd_rdy[k];
        e.sd   = e.st ? disp_sd[k] : 32'h0;
        mq.push_back(m_wake(e));
      end
    for (int k = 0; k < DISPATCH; k++) m_ar[k] = (DEPTH - mq.size()) > k;
  endtask

  task automatic check_output();
    bit          f;
    int          p;
    logic [31:0] va, wd;
    m_pick(f, p);
    chk("iss_valid", iss_valid, f);
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("alloc_ready", alloc_ready, m_ar);
    if (f) begin
      va = mq[p].base + mq[p].imm;
      wd = mq[p].st ? mq[p].sd : 32'h0;
      chk("iss_reorder", iss_reorder, mq[p].rob);
      chk("iss_is_store", iss_is_store, mq[p].st);
      chk("iss_size", iss_size, mq[p].size);
      chk("iss_vaddr", iss_vaddr, va);
      chk("iss_wdata", iss_wdata, wd);
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic idle(input bit ready);
    rst = 1'b0; flush = 1'b0; iss_ready = ready;
    disp_valid = '0; disp_reorder = '0; disp_is_store = '0; disp_size = '0;
    disp_imm = '0; disp_base_rdy = '0; disp_sd_rdy = '0; disp_base = '0; disp_sd = '0;
    cdb_valid = '0; cdb_reorder = '0; cdb_value = '0;
  endtask

  task automatic set_disp(input int k, input logic [4:0] rob, input bit st, input bit brdy,
                          input logic [31:0] base, input logic [31:0] imm,
                          input bit srdy, input logic [31:0] sd);
    disp_valid[k] = 1'b1; disp_reorder[k] = rob; disp_is_store[k] = st;
    disp_size[k] = 2'(k + 1); disp_imm[k] = imm; disp_base_rdy[k] = brdy;
    disp_base[k] = base; disp_sd_rdy[k] = srdy; disp_sd[k] = sd;
  endtask

  task automatic set_cdb(input int j, input logic [4:0] rob, input logic [31:0] value);
    cdb_valid[j] = 1'b1; cdb_reorder[j] = rob; cdb_value[j] = value;
  endtask

  function automatic logic [31:0] rand_operand(input bit rdy);
    logic [31:0] v;
    v = $urandom;
    if (!rdy) v[4:0] = 5'($urandom_range(0, 7));
    return v;
  endfunction

  task automatic apply_stimulus();
    idle($urandom_range(0, 3) != 0);
    flush = ($urandom_range(0, 63) == 0);
    for (int k = 0; k < DISPATCH; k++) begin
      disp_valid[k]    = $urandom_range(0, 1);
      disp_reorder[k]  = 5'($urandom);
      disp_is_store[k] = ($urandom_range(0, 2) == 0);
      disp_size[k]     = 2'($urandom);
      disp_imm[k]      = $urandom;
      disp_base_rdy[k] = $urandom_range(0, 1);
      disp_sd_rdy[k]   = $urandom_range(0, 1);
      disp_base[k]     = rand_operand(disp_base_rdy[k]);
      disp_sd[k]       = rand_operand(disp_sd_rdy[k]);
    end
    for (int j = 0; j < CDB_N; j++) begin
      cdb_valid[j]   = $urandom_range(0, 1);
      cdb_reorder[j] = 5'($urandom_range(0, 7));
      cdb_value[j]   = $urandom;
    end
  endtask

  initial begin
    idle(1'b0);
    rst = 1'b1;
    tick();

    // Two ready loads issue back to back in dispatch order
    idle(1'b1);
    set_disp(0, 5'd3, 1'b0, 1'b1, 32'h100, 32'd4, 1'b0, 32'h0);
    set_disp(1, 5'd4, 1'b0, 1'b1, 32'h100, 32'd8, 1'b0, 32'h0);
    tick();
    chk("t1_vaddr_rob3", iss_vaddr, 32'h104);
    idle(1'b1); tick();
    chk("t1_vaddr_rob4", iss_vaddr, 32'h108);
    idle(1'b1); tick();
    chk("t1_empty", empty, 1'b1);

    // Store waiting on data blocks a younger ready load until CDB tag 7 arrives
    idle(1'b1);
    set_disp(0, 5'd1, 1'b1, 1'b1, 32'h200, 32'h0, 1'b0, 32'd7);
    set_disp(1, 5'd2, 1'b0, 1'b1, 32'h300, 32'h0, 1'b0, 32'h0);
    tick();
    chk("t2_blocked", iss_valid, 1'b0);
    idle(1'b1); set_cdb(0, 5'd7, 32'hAB); tick();
    chk("t2_wdata", iss_wdata, 32'hAB);
    idle(1'b1); tick();
    chk("t2_load_next", iss_reorder, 5'd2);
    idle(1'b1); tick();

    // Presented ROB5 stays locked while older ROB4 wakes
    idle(1'b0);
    set_disp(0, 5'd4, 1'b0, 1'b0, 32'd9, 32'h0, 1'b0, 32'h0);
    set_disp(1, 5'd5, 1'b0, 1'b1, 32'h500, 32'h0, 1'b0, 32'h0);
    tick();
    idle(1'b0); set_cdb(1, 5'd9, 32'h900); tick();
    chk("t3_hold", iss_reorder, 5'd5);
    idle(1'b0); tick();
    idle(1'b1); tick();
    chk("t3_older_next", iss_reorder, 5'd4);
    idle(1'b1); tick();

    // Fill all entries with unready loads
    for (int c = 0; c < 4; c++) begin
      idle(1'b0);
      set_disp(0, 5'(10 + 2 * c), 1'b0, 1'b0, 32'(10 + 2 * c), 32'h0, 1'b0, 32'h0);
      set_disp(1, 5'(11 + 2 * c), 1'b0, 1'b0, 32'(11 + 2 * c), 32'h0, 1'b0, 32'h0);
      tick();
    end
    chk("t4_full_ar", alloc_ready, 2'b00);
    chk("t4_full_count", count, 4'd8);
    idle(1'b0);
    set_disp(0, 5'd30, 1'b0, 1'b1, 32'h7000, 32'h0, 1'b0, 32'h0);
    set_cdb(0, 5'd10, 32'h1000);
    tick();
    idle(1'b1); tick();
    chk("t4_ar_after_accept", alloc_ready, 2'b01);

    // Same-cycle CDB capture at dispatch
    idle(1'b0);
    set_disp(0, 5'd20, 1'b0, 1'b0, 32'd20, 32'h10, 1'b0, 32'h0);
    set_cdb(0, 5'd20, 32'h5500);
    tick();
    chk("t5_vaddr", iss_vaddr, 32'h5510);
    idle(1'b1); tick();

    idle(1'b0); flush = 1'b1; tick();

    // Flush during a locked issue with six entries
    idle(1'b0);
    set_disp(0, 5'd21, 1'b0, 1'b1, 32'h2100, 32'h0, 1'b0, 32'h0);
    set_disp(1, 5'd22, 1'b0, 1'b0, 32'd30, 32'h0, 1'b0, 32'h0);
    tick();
    for (int c = 0; c < 2; c++) begin
      idle(1'b0);
      set_disp(0, 5'(23 + 2 * c), 1'b0, 1'b0, 32'd30, 32'h0, 1'b0, 32'h0);
      set_disp(1, 5'(24 + 2 * c), 1'b0, 1'b0, 32'd30, 32'h0, 1'b0, 32'h0);
      tick();
    end
    chk("t6_count6", count, 4'd6);
    idle(1'b1); flush = 1'b1;
    set_disp(0, 5'd1, 1'b0, 1'b1, 32'h1, 32'h0, 1'b0, 32'h0);
    set_disp(1, 5'd2, 1'b0, 1'b1, 32'h2, 32'h0, 1'b0, 32'h0);
    set_cdb(0, 5'd30, 32'h3);
    tick();
    chk("t6_iss_valid", iss_valid, 1'b0);
    chk("t6_count", count, 4'd0);
    chk("t6_ar", alloc_ready, 2'b11);

    // Address wraps modulo 2^32
    idle(1'b1);
    set_disp(0, 5'd6, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'd8, 1'b0, 32'h0);
    tick();
    chk("t7_wrap", iss_vaddr, 32'h4);
    idle(1'b1); tick();

    for (int n = 0; n < 800; n++) begin
      apply_stimulus();
      tick();
    end

    $display("[TB] random phase complete, %0d failing comparisons", fails);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
